// File: rtl/bip_pkg.sv
// Shared encodings for the BIP control unit and the accumulator datapath.
package bip_pkg;

    localparam int OPCODE_W = 5;

    // Opcodes (instruction bits [15:11])
    localparam logic [OPCODE_W-1:0] OPC_HLT  = 5'b00000;
    localparam logic [OPCODE_W-1:0] OPC_STO  = 5'b00001;
    localparam logic [OPCODE_W-1:0] OPC_LD   = 5'b00010;
    localparam logic [OPCODE_W-1:0] OPC_LDI  = 5'b00011;
    localparam logic [OPCODE_W-1:0] OPC_ADD  = 5'b00100;
    localparam logic [OPCODE_W-1:0] OPC_ADDI = 5'b00101;
    localparam logic [OPCODE_W-1:0] OPC_SUB  = 5'b00110;
    localparam logic [OPCODE_W-1:0] OPC_SUBI = 5'b00111;

    // Accumulator source select
    localparam logic [1:0] SEL_DM  = 2'b00;
    localparam logic [1:0] SEL_IMM = 2'b01;
    localparam logic [1:0] SEL_BAU = 2'b10;

    // BAU B-operand select
    localparam logic SELB_IMM = 1'b0;
    localparam logic SELB_DM  = 1'b1;

    // BAU operation
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       wr_acc;
        logic       op;
        logic       wr_ram;
        logic       rd_ram;
    } ctrl_t;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode-to-control map; the FSM decides when these are visible.
module bip_decoder
    import bip_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_t               ctrl
);

    // Map each opcode to its datapath controls; unknown opcodes decode as NOP
    always_comb begin
        ctrl = '0;
        case (opcode)
            OPC_STO: begin
                ctrl.wr_ram = 1'b1;
            end
            OPC_LD: begin
                ctrl.wr_acc = 1'b1;
                ctrl.sel_a  = SEL_DM;
                ctrl.rd_ram = 1'b1;
            end
            OPC_LDI: begin
                ctrl.wr_acc = 1'b1;
                ctrl.sel_a  = SEL_IMM;
            end
            OPC_ADD: begin
                ctrl.wr_acc = 1'b1;
                ctrl.sel_a  = SEL_BAU;
                ctrl.sel_b  = SELB_DM;
                ctrl.op     = OP_ADD;
                ctrl.rd_ram = 1'b1;
            end
            OPC_ADDI: begin
                ctrl.wr_acc = 1'b1;
                ctrl.sel_a  = SEL_BAU;
                ctrl.sel_b  = SELB_IMM;
                ctrl.op     = OP_ADD;
            end
            OPC_SUB: begin
                ctrl.wr_acc = 1'b1;
                ctrl.sel_a  = SEL_BAU;
                ctrl.sel_b  = SELB_DM;
                ctrl.op     = OP_SUB;
                ctrl.rd_ram = 1'b1;
            end
            OPC_SUBI: begin
                ctrl.wr_acc = 1'b1;
                ctrl.sel_a  = SEL_BAU;
                ctrl.sel_b  = SELB_IMM;
                ctrl.op     = OP_SUB;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/bip_control.sv
// BIP instruction sequencer: PC, instruction register, fetch/decode/exec FSM
// and execution cycle counter.
module bip_control
    import bip_pkg::*;
#(
    parameter int PC_W  = 11,
    parameter int OPC_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_in,
    input  logic [15:0]      Instr_in,
    output logic [PC_W-1:0]  Addr_PM_out,
    output logic [PC_W-1:0]  Operand_out,
    output logic [1:0]       SelA_out,
    output logic             SelB_out,
    output logic             WrAcc_out,
    output logic             Op_out,
    output logic             WrRam_out,
    output logic             RdRam_out,
    output logic             halted_out,
    output logic             done_out,
    output logic [CNT_W-1:0] clk_count_out
);

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q;
    logic [15:0]      ir_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic [OPC_W-1:0] opcode;
    ctrl_t            dec;

    // In DECODE the fresh instruction word drives the decoder so the data
    // memory read can be issued a cycle ahead of EXEC.
    assign opcode = (state_q == ST_DECODE) ? Instr_in[15 -: OPC_W] : ir_q[15 -: OPC_W];

    bip_decoder u_decoder (
        .opcode (opcode),
        .ctrl   (dec)
    );

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_in) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = (Instr_in[15 -: OPC_W] == OPC_HLT) ? ST_HALT : ST_EXEC;
            ST_EXEC:   state_d = ST_FETCH;
            ST_HALT:   if (start_in) state_d = ST_FETCH;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State, PC, IR, counter and done-pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == ST_DECODE) && (state_d == ST_HALT);
            case (state_q)
                ST_IDLE, ST_HALT: begin
                    if (start_in) begin
                        pc_q  <= '0;
                        cnt_q <= '0;
                    end
                end
                ST_FETCH: begin
                    if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                end
                ST_DECODE: begin
                    ir_q <= Instr_in;
                    if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                end
                ST_EXEC: begin
                    pc_q <= pc_q + 1'b1;
                    if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Gate decoded controls by state; reset suppresses every strobe at once
    always_comb begin
        SelA_out   = '0;
        SelB_out   = 1'b0;
        WrAcc_out  = 1'b0;
        Op_out     = 1'b0;
        WrRam_out  = 1'b0;
        RdRam_out  = 1'b0;
        halted_out = 1'b0;
        done_out   = 1'b0;
        if (!reset) begin
            halted_out = (state_q == ST_HALT);
            done_out   = done_q;
            if (state_q == ST_DECODE) begin
                RdRam_out = dec.rd_ram;
            end else if (state_q == ST_EXEC) begin
                SelA_out  = dec.sel_a;
                SelB_out  = dec.sel_b;
                WrAcc_out = dec.wr_acc;
                Op_out    = dec.op;
                WrRam_out = dec.wr_ram;
            end
        end
    end

    assign Addr_PM_out   = pc_q;
    assign Operand_out   = (state_q == ST_DECODE) ? Instr_in[PC_W-1:0] : ir_q[PC_W-1:0];
    assign clk_count_out = cnt_q;

endmodule
